// File: rtl/hm01b0_sim.sv
// Behavioural HM01B0 camera model: streams a preloaded grayscale image as
// pixdata with LVLD (hsync) / FVLD (vsync) framing and a pixel clock of ~mclk.
module hm01b0_sim #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int H_BLANK = 80,
    parameter int V_BLANK = 8
) (
    input  logic       mclk,
    input  logic       nreset,
    output logic       clock,
    output logic [7:0] pixdata,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOTAL = WIDTH + H_BLANK;
    localparam int V_TOTAL = HEIGHT + V_BLANK;
    localparam int PIXELS  = WIDTH * HEIGHT;
    // One spare bit so the active-region limits always fit, even with no blanking.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int AW = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    localparam logic [HW-1:0] H_ACT  = HW'(WIDTH);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(HEIGHT);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [AW-1:0] ROW_STRIDE = AW'(WIDTH);

    logic [7:0] hm01b0_image [0:PIXELS-1];

    logic [HW-1:0] h_r;
    logic [VW-1:0] v_r;
    logic [7:0]    pixdata_r;
    logic          hsync_r;
    logic          vsync_r;

    logic          v_active_s;
    logic          active_s;
    logic [AW-1:0] addr_s;

    // Decode the current raster position into active flags and image address.
    always_comb begin
        v_active_s = (v_r < V_ACT);
        active_s   = (h_r < H_ACT) && v_active_s;
        addr_s     = AW'(v_r) * ROW_STRIDE + AW'(h_r);
    end

    // Raster counters: h wraps every line period, v steps on each h wrap.
    always_ff @(posedge mclk) begin
        if (!nreset) begin
            h_r <= {HW{1'b0}};
            v_r <= {VW{1'b0}};
        end else if (h_r == H_LAST) begin
            h_r <= {HW{1'b0}};
            if (v_r == V_LAST) begin
                v_r <= {VW{1'b0}};
            end else begin
                v_r <= v_r + VW'(1'b1);
            end
        end else begin
            h_r <= h_r + HW'(1'b1);
        end
    end

    // Output stage samples the position before the counters move on.
    always_ff @(posedge mclk) begin
        if (!nreset) begin
            pixdata_r <= 8'h00;
            hsync_r   <= 1'b0;
            vsync_r   <= 1'b0;
        end else begin
            vsync_r <= v_active_s;
            if (active_s) begin
                hsync_r   <= 1'b1;
                pixdata_r <= hm01b0_image[addr_s];
            end else begin
                hsync_r   <= 1'b0;
                pixdata_r <= 8'h00;
            end
        end
    end

    assign clock   = ~mclk;
    assign pixdata = pixdata_r;
    assign hsync   = hsync_r;
    assign vsync   = vsync_r;

endmodule

// File: tb/tb_hm01b0_sim.sv
// Directed bench: full-size instance for reset/line behaviour, a shrunken
// instance (8x4, blanking 2/1) for whole-frame timing and wrap-around.
module tb_hm01b0_sim;

    logic       mclk = 1'b0;
    logic       nreset;
    logic       nreset_small;
    logic       clock,   clock_small;
    logic [7:0] pixdata, pixdata_small;
    logic       hsync,   hsync_small;
    logic       vsync,   vsync_small;

    int errors = 0;
    int checks = 0;

    hm01b0_sim dut (
        .mclk    (mclk),
        .nreset  (nreset),
        .clock   (clock),
        .pixdata (pixdata),
        .hsync   (hsync),
        .vsync   (vsync)
    );

    hm01b0_sim #(.WIDTH(8), .HEIGHT(4), .H_BLANK(2), .V_BLANK(1)) dut_small (
        .mclk    (mclk),
        .nreset  (nreset_small),
        .clock   (clock_small),
        .pixdata (pixdata_small),
        .hsync   (hsync_small),
        .vsync   (vsync_small)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({hsync, vsync, pixdata} !== 10'b0) begin
                errors++;
                $display("FAIL reset_outputs c=%0d got hs=%b vs=%b pix=%h exp 0 0 00", c, hsync, vsync, pixdata);
            end
            checks++;
            if (clock !== 1'b0) begin
                errors++;
                $display("FAIL reset_clock_hi got clock=%b exp 0 (mclk=1)", clock);
            end
            @(negedge mclk);
            #1;
            checks++;
            if (clock !== 1'b1) begin
                errors++;
                $display("FAIL reset_clock_lo got clock=%b exp 1 (mclk=0)", clock);
            end
        end
    endtask

    // Cycle n after release shows raster position n-1 of the 400x248 raster.
    task automatic test_lines(input int first, input int last);
        int pos, h, v;
        logic       ehs, evs;
        logic [7:0] epix;
        for (int c = first; c <= last; c++) begin
            tick();
            pos  = c - 1;
            h    = pos % 400;
            v    = pos / 400;
            ehs  = (h < 320) && (v < 240);
            evs  = (v < 240);
            epix = ehs ? 8'(v * 320 + h) : 8'h00;
            checks++;
            if ({hsync, vsync, pixdata} !== {ehs, evs, epix}) begin
                errors++;
                $display("FAIL line_px cyc=%0d got hs=%b vs=%b pix=%h exp hs=%b vs=%b pix=%h",
                         c, hsync, vsync, pixdata, ehs, evs, epix);
            end
            if (c == 401) begin
                checks++;
                if (pixdata !== 8'h40) begin
                    errors++;
                    $display("FAIL line1_first_px got %h exp 40", pixdata);
                end
            end
        end
    endtask

    task automatic test_midline_reset();
        nreset = 1'b0;
        tick();
        checks++;
        if ({hsync, vsync, pixdata} !== 10'b0) begin
            errors++;
            $display("FAIL midline_reset_edge got hs=%b vs=%b pix=%h exp 0 0 00", hsync, vsync, pixdata);
        end
        nreset = 1'b1;
        tick();
        checks++;
        if ({hsync, vsync, pixdata} !== {1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL midline_restart_px0 got hs=%b vs=%b pix=%h exp 1 1 00", hsync, vsync, pixdata);
        end
        tick();
        checks++;
        if ({hsync, vsync, pixdata} !== {1'b1, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL midline_restart_px1 got hs=%b vs=%b pix=%h exp 1 1 01", hsync, vsync, pixdata);
        end
    endtask

    // 10-cycle lines, 50-cycle frames; image word i holds 8'h10 + i.
    task automatic test_small_frame();
        int pos, h, v, pulses, high, run;
        logic       ehs, evs, prev_hs;
        logic [7:0] epix;
        pulses  = 0;
        high    = 0;
        run     = 0;
        prev_hs = 1'b0;
        nreset_small = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            pos  = (c - 1) % 50;
            h    = pos % 10;
            v    = pos / 10;
            ehs  = (h < 8) && (v < 4);
            evs  = (v < 4);
            epix = ehs ? 8'(8'h10 + v * 8 + h) : 8'h00;
            checks++;
            if ({hsync_small, vsync_small, pixdata_small} !== {ehs, evs, epix}) begin
                errors++;
                $display("FAIL small_px cyc=%0d got hs=%b vs=%b pix=%h exp hs=%b vs=%b pix=%h",
                         c, hsync_small, vsync_small, pixdata_small, ehs, evs, epix);
            end
            if (c <= 50) begin
                if (hsync_small && !prev_hs) pulses++;
                if (hsync_small) high++;
            end
            if (hsync_small) begin
                run++;
            end else begin
                if (prev_hs) begin
                    checks++;
                    if (run != 8) begin
                        errors++;
                        $display("FAIL small_pulse_len cyc=%0d got %0d exp 8", c, run);
                    end
                end
                run = 0;
            end
            prev_hs = hsync_small;
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL small_pulse_count got %0d exp 4", pulses);
        end
        checks++;
        if (high != 32) begin
            errors++;
            $display("FAIL small_hsync_cycles got %0d exp 32", high);
        end
    endtask

    initial begin
        nreset       = 1'b0;
        nreset_small = 1'b0;
        for (int i = 0; i < 320 * 240; i++) dut.hm01b0_image[i] = 8'(i);
        for (int i = 0; i < 32; i++) dut_small.hm01b0_image[i] = 8'(8'h10 + i);

        test_reset();
        nreset = 1'b1;
        test_lines(1, 400);
        test_lines(401, 2100);
        test_midline_reset();
        test_small_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hm01b0_sim.md
HM01B0_SIM -- requirements
Module: hm01b0_sim

Interface
REQ-001 Parameter WIDTH, default 320: active pixels per line.
REQ-002 Parameter HEIGHT, default 240: active lines per frame.
REQ-003 Parameter H_BLANK, default 80: blank pixel periods after each line's active pixels.
REQ-004 Parameter V_BLANK, default 8: blank lines (full line periods) after the last active line.
REQ-005 mclk  input  1  sole clock; all registers update on its rising edge.
REQ-006 nreset  input  1  reset, synchronous, active-low.
REQ-007 clock  output  1  pixel clock to the consumer; SHALL equal ~mclk (combinational), so outputs change on clock falling edge and are stable at clock rising edge.
REQ-008 pixdata  output  8  grayscale pixel value, registered.
REQ-009 hsync  output  1  line-valid (LVLD), high only while pixdata carries an active pixel, registered.
REQ-010 vsync  output  1  frame-valid (FVLD), high for the whole active-line region of a frame, registered.
REQ-011 Internal memory SHALL be named hm01b0_image: 8-bit words, WIDTH*HEIGHT entries, row-major (index = row*WIDTH + col); testbenches load it by hierarchical $readmemh; module never writes it.

Function
REQ-012 Horizontal counter h counts 0..WIDTH+H_BLANK-1 and wraps to 0.
REQ-013 Vertical counter v increments when h wraps, counts 0..HEIGHT+V_BLANK-1, and wraps to 0 at frame end.
REQ-014 Each mclk rising edge with nreset=1: outputs load from the current (h,v); counters then advance; output latency = 1 mclk.
REQ-015 Active when h<WIDTH and v<HEIGHT: hsync<=1, pixdata<=hm01b0_image[v*WIDTH+h].
REQ-016 Not active: hsync<=0, pixdata<=8'h00.
REQ-017 vsync<=1 when v<HEIGHT (including that line's horizontal blanking), else 0.
REQ-018 Line period = WIDTH+H_BLANK mclk cycles (400 default); hsync high exactly WIDTH consecutive cycles per active line.
REQ-019 Frame period = (WIDTH+H_BLANK)*(HEIGHT+V_BLANK) cycles (99200 default); frames repeat indefinitely, no gap beyond V_BLANK.
REQ-020 hsync and vsync rise on the same edge at a frame's first pixel; vsync falls on the edge after the last active line's blanking ends.
REQ-021 No hsync pulse during vertical blanking.

Reset
REQ-022 While nreset=0 at a mclk rising edge: h<=0, v<=0, hsync<=0, vsync<=0, pixdata<=0.
REQ-023 First rising edge with nreset=1 outputs pixel (0,0) (hsync=vsync=1, pixdata=hm01b0_image[0]).
REQ-024 Reset asserted mid-line or mid-frame discards position; the next frame restarts from (0,0) after release.
REQ-025 clock follows ~mclk regardless of nreset.

Verification
REQ-026 Hold nreset=0 for 3 cycles -> hsync=vsync=0, pixdata=0 each cycle; clock toggles inverted from mclk.
REQ-027 Load hm01b0_image[i]=i[7:0], release reset -> cycles 1..320 hsync=1, vsync=1, pixdata=0,1,...,255,0,...,63; cycles 321..400 hsync=0, vsync=1, pixdata=0.
REQ-028 Same image -> line 1 starts at cycle 401 with pixdata=hm01b0_image[320]=8'h40; count 240 hsync pulses per frame.
REQ-029 After line 239 blanking -> vsync=0, hsync=0 for 3200 cycles; cycle 99201 outputs pixel (0,0) again with vsync=1.
REQ-030 Assert nreset=0 mid-line 5 at pixel 100 for 1 cycle -> outputs 0 that edge; next edge outputs pixel (0,0).
REQ-031 Override WIDTH=8, HEIGHT=4, H_BLANK=2, V_BLANK=1 -> line period 10, frame period 50, 4 hsync pulses of 8 cycles.
